spi_snoop_bridge: RTL and testbench
===================================

# spi_snoop_bridge

Parametrised SPI-slave-to-snoop-port bridge: the next generation of the software SPI front end feeding the discus CPU snoop interface. It oversamples SCK/SSEL/MOSI on the system clock and decodes a 2-bit opcode per frame. It then streams any number of address or data words per SSEL-low frame, with auto-increment and prefetched burst reads. Address and data widths are parameters, and malformed frames are counted.

## Interface
- ADDR_W, 8, snoop address width (≥2).
- DATA_W, 8, snoop data width (≥2).
- SYNC_STAGES, 2, input synchroniser depth (≥2).
- clk  in  1  system clock; SCK period must be ≥ 8 clk, each phase ≥ 4 clk.
- reset  in  1  asynchronous, active-high.
- spi_sck  in  1  SPI clock, idle low (mode 0).
- spi_ssel  in  1  slave select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first; reset 0.
- snoopa  out  ADDR_W  snoop address; reset 0.
- snoopd  out  DATA_W  snoop write data; reset 0.
- snoopq  in  DATA_W  snoop read data, valid 1 clk after snoopa changes.
- snoopp  out  1  program-write strobe, 1 clk; reset 0.
- snoopm  out  1  memory-write strobe, 1 clk; reset 0.
- frame_errs  out  8  saturating malformed-frame count; reset 0.

## Operation
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised signals: sck_rise, ssel_rise (frame end), ssel_fall (frame start).
- MOSI is sampled at sck_rise. Edges are ignored while synchronised SSEL is high.
- Frame structure: 2 opcode bits, then words. Word width is ADDR_W for OP_ADDR and DATA_W otherwise.
- OP_ADDR (00): each complete word loads snoopa. The last complete word wins.
- OP_PROG (01): each complete word loads snoopd and pulses snoopp. snoopa increments the following clk.
- OP_MEM (11): same as OP_PROG, but pulses snoopm.
- OP_READ (10): two-stage prefetch, using a shift register and a hold register.
  - At opcode completion with snoopa=A: fetch A into shift, then snoopa←A+1, then fetch into hold.
  - At each read-word completion: shift←hold, snoopa++, refetch into hold.
  - MISO presents the shift MSB and shifts left at every sck_rise within a word.
  - MISO is 0 during opcode bits.
  - At frame end, snoopa is set to A + completed read words. Prefetch overshoot is discarded.
- snoopa arithmetic is modulo 2^ADDR_W: 2^ADDR_W−1 increments to 0.
- Frame error, on ssel_rise: opcode incomplete, or word bit count nonzero.
  - frame_errs increments, saturating at 255.
  - The partial word is discarded, with no strobe and no snoopa/snoopd change.
  - Complete words earlier in the frame are retained.
- Arming: after reset, frames are ignored until synchronised SSEL has been seen high. A reset mid-frame drops that frame silently.
- ssel_rise and sck_rise in the same clk: the SCK edge is ignored and the frame ends.
- Frame end returns the bit counter and opcode to idle. spi_miso←0.

## Timing
- Pin-to-internal latency is SYNC_STAGES+1 clk.
- Write strobes assert 1 clk after the sck_rise detect of the word's last bit.
- snoopa increments 1 clk after the strobe.
- MISO valid: ≤3 clk after the opcode-completing sck_rise detect. Thereafter it updates 1 clk after each sck_rise detect.
  - This satisfies host sampling at the next rising edge given the SCK constraint.
- Back-to-back frames need ≥2 clk of SSEL high after synchronisation.
- State machine: IDLE→OPC (ssel_fall, armed)→WORD (2 bits)→WORD (repeat)→IDLE (ssel_rise). From any state, reset→IDLE with armed=0.

## Structure
- Shared package discus_spi_pkg holds the OP_ADDR/OP_PROG/OP_READ/OP_MEM localparams and a state enum typedef.
- One sub-module, spi_edge_sync: synchroniser plus rise/fall detector, parametrised by SYNC_STAGES, instantiated three times.
- The bit counter width is $clog2(max(ADDR_W,DATA_W)+1).

## Test plan
- Address frame 00+0x5A then 0x3C (ADDR_W=8) -> snoopa=0x3C, no strobes, frame_errs=0.
- Frame 11 with words 0x11,0x22,0x33 at snoopa=0xFE -> snoopm three times; snoopd/snoopa pairs (0x11,FE),(0x22,FF),(0x33,00); final snoopa=0x01.
- Read frame 10, two words, model memory[n]=n^0xA5, snoopa=0x10 -> MISO bytes 0xB5,0xB4; final snoopa=0x12.
- Frame 01 aborted after 5 data bits -> no snoopp, snoopd unchanged, frame_errs=1. 300 such frames -> frame_errs=255.
- Reset asserted mid-write with SSEL still low -> outputs at reset values; the remaining bits of that frame are ignored. The next full frame 00+0x07 -> snoopa=0x07.
- ADDR_W=12, DATA_W=16: frame 00+0xABC then 01+0xBEEF -> snoopp once with snoopa=0xABC, snoopd=0xBEEF; snoopa=0xABD after.

Source files
------------

// File: rtl/discus_spi_pkg.sv
// Shared opcode values and frame-decoder state type for the discus SPI snoop bridge.
package discus_spi_pkg;

    localparam logic [1:0] OP_ADDR = 2'b00;
    localparam logic [1:0] OP_PROG = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_MEM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPC  = 2'd1,
        ST_WORD = 2'd2
    } state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin with rise/fall detection
// on the synchronised level.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Synchroniser chain plus one extra flop holding the previous level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_snoop_bridge.sv
// SPI mode-0 slave that decodes opcode-prefixed frames into snoop-port address
// loads, program/memory write strobes and prefetched burst reads.
module spi_snoop_bridge
    import discus_spi_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ssel,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] snoopa,
    output logic [DATA_W-1:0] snoopd,
    input  logic [DATA_W-1:0] snoopq,
    output logic              snoopp,
    output logic              snoopm,
    output logic [7:0]        frame_errs
);

    localparam int MAX_W = max_w(ADDR_W, DATA_W);
    localparam int CNT_W = $clog2(MAX_W + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic ssel_lvl, ssel_rise, ssel_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic edge_unused;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .reset(reset), .din(spi_sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ssel (
        .clk(clk), .reset(reset), .din(spi_ssel),
        .level(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall));
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

    assign edge_unused = ^{sck_lvl, sck_fall, mosi_rise, mosi_fall};

    state_t                state_q, state_d;
    logic                  armed;
    logic [CNT_W-1:0]      bit_cnt;
    logic [1:0]            op_q;
    logic [1:0]            rd_step;
    logic [ADDR_W-1:0]     rd_words;
    logic [ADDR_W-1:0]     rd_base;
    logic [MAX_W-2:0]      in_sh;
    logic [DATA_W-2:0]     shift_q;
    logic [DATA_W-1:0]     hold_q;

    logic                  sck_ev, frame_end, bad_frame, op_done, word_done;
    logic [1:0]            opc_new;
    logic [CNT_W-1:0]      last_idx;
    logic                  shift_from_q, hold_load, rd_word_done, rd_shift;
    logic [ADDR_W-1:0]     addr_word;
    logic [DATA_W-1:0]     data_word;

    assign opc_new   = {op_q[0], mosi_lvl};
    assign last_idx  = (op_q == OP_ADDR) ? CNT_W'(ADDR_W - 1) : CNT_W'(DATA_W - 1);
    assign addr_word = {in_sh[ADDR_W-2:0], mosi_lvl};
    assign data_word = {in_sh[DATA_W-2:0], mosi_lvl};

    assign shift_from_q = (rd_step == 2'd1);
    assign hold_load    = (rd_step == 2'd3);
    assign rd_word_done = word_done && (op_q == OP_READ);
    assign rd_shift     = sck_ev && (state_q == ST_WORD) && (op_q == OP_READ) && !word_done;

    // Frame state register; reset drops any frame in flight and disarms.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; frame end beats a coincident SCK edge.
    always_comb begin
        state_d   = state_q;
        sck_ev    = 1'b0;
        frame_end = 1'b0;
        bad_frame = 1'b0;
        op_done   = 1'b0;
        word_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ssel_fall && armed) state_d = ST_OPC;
            end
            ST_OPC: begin
                if (ssel_rise) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                    bad_frame = 1'b1;
                end else if (sck_rise && !ssel_lvl) begin
                    sck_ev = 1'b1;
                    if (bit_cnt == CNT_W'(1)) begin
                        op_done = 1'b1;
                        state_d = ST_WORD;
                    end
                end
            end
            ST_WORD: begin
                if (ssel_rise) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                    bad_frame = (bit_cnt != '0);
                end else if (sck_rise && !ssel_lvl) begin
                    sck_ev    = 1'b1;
                    word_done = (bit_cnt == last_idx);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and snoop-port outputs: counters, strobes, address updates, MISO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed      <= 1'b0;
            bit_cnt    <= '0;
            op_q       <= OP_ADDR;
            rd_step    <= 2'd0;
            rd_words   <= '0;
            snoopa     <= '0;
            snoopd     <= '0;
            snoopp     <= 1'b0;
            snoopm     <= 1'b0;
            spi_miso   <= 1'b0;
            frame_errs <= '0;
        end else begin
            snoopp <= 1'b0;
            snoopm <= 1'b0;
            if (ssel_lvl) armed <= 1'b1;
            if (snoopp || snoopm) snoopa <= snoopa + ADDR_W'(1);

            case (rd_step)
                2'd1: begin
                    snoopa   <= snoopa + ADDR_W'(1);
                    rd_step  <= 2'd2;
                    spi_miso <= snoopq[DATA_W-1];
                end
                2'd2:    rd_step <= 2'd3;
                2'd3:    rd_step <= 2'd0;
                default: rd_step <= 2'd0;
            endcase

            if (rd_shift) spi_miso <= shift_q[DATA_W-2];

            if (sck_ev) begin
                bit_cnt <= (op_done || word_done) ? '0 : bit_cnt + CNT_W'(1);
                if (state_q == ST_OPC) op_q <= opc_new;
            end

            if (op_done && opc_new == OP_READ) begin
                rd_step  <= 2'd1;
                rd_words <= '0;
            end

            if (word_done) begin
                case (op_q)
                    OP_ADDR: snoopa <= addr_word;
                    OP_PROG: begin
                        snoopd <= data_word;
                        snoopp <= 1'b1;
                    end
                    OP_MEM: begin
                        snoopd <= data_word;
                        snoopm <= 1'b1;
                    end
                    default: begin
                        snoopa   <= snoopa + ADDR_W'(1);
                        rd_step  <= 2'd2;
                        rd_words <= rd_words + ADDR_W'(1);
                        spi_miso <= hold_q[DATA_W-1];
                    end
                endcase
            end

            if (frame_end) begin
                bit_cnt  <= '0;
                op_q     <= OP_ADDR;
                rd_step  <= 2'd0;
                spi_miso <= 1'b0;
                if (bad_frame && frame_errs != 8'hFF) frame_errs <= frame_errs + 8'd1;
                if (op_q == OP_READ && state_q == ST_WORD) snoopa <= rd_base + rd_words;
            end
        end
    end

    // Datapath registers: incoming word shifter and the two read prefetch stages.
    always_ff @(posedge clk) begin
        if (sck_ev) in_sh <= (MAX_W-1)'({in_sh, mosi_lvl});
        if (shift_from_q)      shift_q <= snoopq[DATA_W-2:0];
        else if (rd_word_done) shift_q <= hold_q[DATA_W-2:0];
        else if (rd_shift)     shift_q <= (DATA_W-1)'({shift_q, 1'b0});
        if (hold_load) hold_q  <= snoopq;
        if (op_done)   rd_base <= snoopa;
    end

endmodule

// File: tb/tb_spi_snoop_bridge.sv
// Directed and randomized frame stimulus for spi_snoop_bridge, checked against
// a frame-level model of the snoop port.
module tb_spi_snoop_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_ssel = 1'b1;
    logic        spi_mosi = 1'b0;

    logic        miso8;
    logic [7:0]  snoopa8, snoopd8, snoopq8;
    logic        snoopp8, snoopm8;
    logic [7:0]  errs8;

    logic        misow;
    logic [11:0] snoopaw;
    logic [15:0] snoopdw, snoopqw;
    logic        snooppw, snoopmw;
    logic [7:0]  errsw;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] p_log[$], m_log[$], pw_log[$];
    logic [31:0] exp_p[$], exp_m[$];
    logic [31:0] tx_q[$], rx_q[$];

    always #5 clk = ~clk;

    spi_snoop_bridge #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_ssel(spi_ssel),
        .spi_mosi(spi_mosi), .spi_miso(miso8), .snoopa(snoopa8), .snoopd(snoopd8),
        .snoopq(snoopq8), .snoopp(snoopp8), .snoopm(snoopm8), .frame_errs(errs8));

    spi_snoop_bridge #(.ADDR_W(12), .DATA_W(16), .SYNC_STAGES(2)) dutw (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_ssel(spi_ssel),
        .spi_mosi(spi_mosi), .spi_miso(misow), .snoopa(snoopaw), .snoopd(snoopdw),
        .snoopq(snoopqw), .snoopp(snooppw), .snoopm(snoopmw), .frame_errs(errsw));

    // Snoop memories: read data appears one clock after the address changes.
    always @(posedge clk) begin
        snoopq8 <= snoopa8 ^ 8'hA5;
        snoopqw <= {4'h0, snoopaw} ^ 16'h5A5A;
    end

    // Strobe monitors log (data, address) at each write pulse.
    always @(negedge clk) begin
        if (snoopp8) p_log.push_back({16'h0, snoopd8, snoopa8});
        if (snoopm8) m_log.push_back({16'h0, snoopd8, snoopa8});
        if (snooppw) pw_log.push_back({snoopdw, 4'h0, snoopaw});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sck_cycle(input logic b, output logic m);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        m = miso8;
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    // Sends opcode, every word in tx_q (MSB first), then 'extra' random bits.
    task automatic send_frame(input logic [1:0] op, input int width, input int extra);
        logic m;
        logic [31:0] w;
        logic [31:0] rw;
        spi_ssel = 1'b0;
        repeat (4) @(negedge clk);
        sck_cycle(op[1], m);
        sck_cycle(op[0], m);
        rx_q.delete();
        foreach (tx_q[i]) begin
            w = tx_q[i];
            rw = 0;
            for (int b = width - 1; b >= 0; b--) begin
                sck_cycle(w[b], m);
                rw = {rw[30:0], m};
            end
            rx_q.push_back(rw);
        end
        for (int b = 0; b < extra; b++) sck_cycle(1'($urandom_range(0, 1)), m);
        repeat (4) @(negedge clk);
        spi_ssel = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic m;
        int m_addr, m_data, m_errs, op, nw, extra, w;

        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_snoopa", 32'(snoopa8), 0);
        check("rst_snoopd", 32'(snoopd8), 0);
        check("rst_snoopp", 32'(snoopp8), 0);
        check("rst_snoopm", 32'(snoopm8), 0);
        check("rst_miso", 32'(miso8), 0);
        check("rst_errs", 32'(errs8), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Address frame: last word wins.
        tx_q = '{32'h5A, 32'h3C};
        send_frame(2'b00, 8, 0);
        check("addr_snoopa", 32'(snoopa8), 32'h3C);
        check("addr_no_strobe", 32'(p_log.size() + m_log.size()), 0);
        check("addr_errs", 32'(errs8), 0);

        // Memory-write burst wrapping through 0xFF.
        tx_q = '{32'hFE};
        send_frame(2'b00, 8, 0);
        tx_q = '{32'h11, 32'h22, 32'h33};
        send_frame(2'b11, 8, 0);
        check("mem_count", 32'(m_log.size()), 3);
        if (m_log.size() == 3) begin
            check("mem_w0", m_log[0], 32'h11FE);
            check("mem_w1", m_log[1], 32'h22FF);
            check("mem_w2", m_log[2], 32'h3300);
        end
        check("mem_no_prog", 32'(p_log.size()), 0);
        check("mem_snoopa", 32'(snoopa8), 32'h01);
        m_log.delete();

        // Burst read with prefetch, address restored to base + words.
        tx_q = '{32'h10};
        send_frame(2'b00, 8, 0);
        tx_q = '{32'h0, 32'h0};
        send_frame(2'b10, 8, 0);
        check("rd_b0", rx_q[0], 32'hB5);
        check("rd_b1", rx_q[1], 32'hB4);
        check("rd_snoopa", 32'(snoopa8), 32'h12);

        // Randomized frames against the frame-level model.
        m_addr = 32'h12; m_data = 32'h33; m_errs = 0;
        for (int f = 0; f < 20; f++) begin
            op = $urandom_range(0, 3);
            nw = $urandom_range(0, 3);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            tx_q.delete();
            for (int k = 0; k < nw; k++) tx_q.push_back(32'($urandom_range(0, 255)));
            exp_p.delete(); exp_m.delete();
            foreach (tx_q[k]) begin
                w = int'(tx_q[k]);
                if (op == 0) m_addr = w;
                else if (op == 1 || op == 3) begin
                    if (op == 1) exp_p.push_back(32'((w << 8) | m_addr));
                    else exp_m.push_back(32'((w << 8) | m_addr));
                    m_data = w;
                    m_addr = (m_addr + 1) % 256;
                end
            end
            send_frame(2'(op), 8, extra);
            if (op == 2) begin
                for (int k = 0; k < nw; k++)
                    check("rnd_rd", rx_q[k], 32'(((m_addr + k) % 256) ^ 8'hA5));
                m_addr = (m_addr + nw) % 256;
            end
            if (extra != 0) m_errs++;
            check("rnd_snoopa", 32'(snoopa8), 32'(m_addr));
            check("rnd_snoopd", 32'(snoopd8), 32'(m_data));
            check("rnd_errs", 32'(errs8), 32'(m_errs));
            check("rnd_pcount", 32'(p_log.size()), 32'(exp_p.size()));
            check("rnd_mcount", 32'(m_log.size()), 32'(exp_m.size()));
            if (p_log.size() == exp_p.size())
                foreach (exp_p[k]) check("rnd_pw", p_log[k], exp_p[k]);
            if (m_log.size() == exp_m.size())
                foreach (exp_m[k]) check("rnd_mw", m_log[k], exp_m[k]);
            p_log.delete(); m_log.delete();
        end

        // Aborted program frames: counted, partial word discarded, saturating.
        tx_q.delete();
        send_frame(2'b01, 8, 5);
        check("abort_no_prog", 32'(p_log.size()), 0);
        check("abort_snoopd", 32'(snoopd8), 32'(m_data));
        check("abort_errs", 32'(errs8), 32'(m_errs + 1));
        for (int f = 0; f < 299; f++) send_frame(2'b01, 8, 5);
        check("sat_errs", 32'(errs8), 255);

        // Reset in the middle of a write frame.
        spi_ssel = 1'b0;
        repeat (4) @(negedge clk);
        sck_cycle(1'b0, m); sck_cycle(1'b1, m);
        for (int b = 0; b < 3; b++) sck_cycle(1'b1, m);
        reset = 1'b1;
        #1;
        check("midrst_snoopa", 32'(snoopa8), 0);
        check("midrst_errs", 32'(errs8), 0);
        check("midrst_snoopd", 32'(snoopd8), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        p_log.delete(); pw_log.delete();
        for (int b = 0; b < 5; b++) sck_cycle(1'b1, m);
        repeat (4) @(negedge clk);
        spi_ssel = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_prog", 32'(p_log.size()), 0);
        check("midrst_snoopd2", 32'(snoopd8), 0);
        check("midrst_errs2", 32'(errs8), 0);
        tx_q = '{32'h07};
        send_frame(2'b00, 8, 0);
        check("postrst_snoopa", 32'(snoopa8), 32'h07);

        // Wide instance: 12-bit address, 16-bit data.
        tx_q = '{32'hABC};
        send_frame(2'b00, 12, 0);
        tx_q = '{32'hBEEF};
        send_frame(2'b01, 16, 0);
        check("wide_pcount", 32'(pw_log.size()), 1);
        if (pw_log.size() == 1) check("wide_pw", pw_log[0], 32'hBEEF0ABC);
        check("wide_snoopd", 32'(snoopdw), 32'hBEEF);
        check("wide_snoopa", 32'(snoopaw), 32'hABD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
